// File: rtl/maj_sched_pkg.sv
// Shared definitions for the round-robin majority scheduler and its serial core.
package maj_sched_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/maj_serial_core.sv
// Serial majority engine: counts ones over WIDTH bits and flags the final bit.
module maj_serial_core
    import maj_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = clog2(WIDTH + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic bit_in_i,
    input  logic bit_en_i,
    output logic last_o,
    output logic maj_o
);

    logic [CW-1:0] ones_q;
    logic [CW-1:0] bitcnt_q;
    logic [CW-1:0] ones_d;

    assign ones_d = ones_q + CW'(bit_in_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ones_q   <= '0;
            bitcnt_q <= '0;
        end else if (clr_i) begin
            ones_q   <= '0;
            bitcnt_q <= '0;
        end else if (bit_en_i) begin
            ones_q   <= ones_d;
            bitcnt_q <= bitcnt_q + 1'b1;
        end
    end

    // Result reflects the count including the bit consumed this cycle; the extra bit keeps 2*ones exact.
    assign last_o = bit_en_i && (bitcnt_q == CW'(WIDTH - 1));
    assign maj_o  = {ones_d, 1'b0} > (CW + 1)'(WIDTH);

endmodule

// File: rtl/maj_scheduler.sv
// Round-robin scheduler feeding latched requester words LSB-first into a shared serial majority core.
module maj_scheduler
    import maj_sched_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = clog2(NREQ),
    localparam int CW    = clog2(WIDTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] data_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  busy_o,
    output logic                  maj_valid_o,
    output logic                  maj_out_o,
    output logic [IDW-1:0]        maj_id_o
);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, id_q;
    logic [WIDTH-1:0] shreg_q;
    logic [IDW-1:0]   winner, hi_win, lo_win;
    logic             hi_found, any_req;
    logic [WIDTH-1:0] sel_word;
    logic             take, clr, bit_en, core_last, core_maj;
    logic [NREQ-1:0]  gnt_d;
    logic             busy_d, valid_d, mout_d;
    logic [IDW-1:0]   mid_d;

    // Lowest request at or above ptr wins, otherwise lowest request overall (wrap).
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                lo_win = IDW'(k);
                if (IDW'(k) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = IDW'(k);
                end
            end
        end
        winner  = hi_found ? hi_win : lo_win;
        any_req = |req_i;
    end

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == IDW'(k)) sel_word = data_i[k*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // DONE arbitrates like IDLE so a waiting request is granted on the edge that ends the result cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = any_req ? S_SHIFT : S_IDLE;
            S_SHIFT:        if (core_last) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        take    = 1'b0;
        clr     = 1'b0;
        bit_en  = 1'b0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        mout_d  = 1'b0;
        mid_d   = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (any_req) begin
                    take   = 1'b1;
                    clr    = 1'b1;
                    busy_d = 1'b1;
                    for (int k = 0; k < NREQ; k++) gnt_d[k] = (winner == IDW'(k));
                end
            end
            S_SHIFT: begin
                bit_en = 1'b1;
                busy_d = 1'b1;
                if (core_last) begin
                    valid_d = 1'b1;
                    mout_d  = core_maj;
                    mid_d   = id_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q     <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            gnt_o       <= '0;
            busy_o      <= 1'b0;
            maj_valid_o <= 1'b0;
            maj_out_o   <= 1'b0;
            maj_id_o    <= '0;
        end else begin
            if (take) begin
                shreg_q <= sel_word;
                id_q    <= winner;
                ptr_q   <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            end else if (bit_en) begin
                shreg_q <= shreg_q >> 1;
            end
            gnt_o       <= gnt_d;
            busy_o      <= busy_d;
            maj_valid_o <= valid_d;
            maj_out_o   <= mout_d;
            maj_id_o    <= mid_d;
        end
    end

    maj_serial_core #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_core (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (clr),
        .bit_in_i (shreg_q[0]),
        .bit_en_i (bit_en),
        .last_o   (core_last),
        .maj_o    (core_maj)
    );

endmodule
